sdc_host_arb: RTL and testbench

SDC_HOST_ARB -- requirements
Module: sdc_host_arb

---
 rtl/sdc_host_arb.sv | 166 ++++++++++++++++
 tb/tb_sdc_host_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_host_arb.sv
// Two-port round-robin arbiter in front of an SDRAM controller host port.
// One transaction is in flight at a time. The winner's request fields are
// latched at grant. Beats are routed back to the granted requester only.
module sdc_host_arb #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 32
) (
   input  logic              mclk,
   input  logic              s_resetn,

   input  logic              p0_req,
   input  logic [ADDR_W-1:0] p0_adr,
   input  logic [1:0]        p0_len,
   input  logic              p0_wr_n,
   input  logic [DATA_W-1:0] p0_wr_data,
   input  logic [3:0]        p0_wr_en_n,
   output logic              p0_ack,
   output logic              p0_rd_valid,
   output logic              p0_wr_next,
   output logic [DATA_W-1:0] p0_rd_data,

   input  logic              p1_req,
   input  logic [ADDR_W-1:0] p1_adr,
   input  logic [1:0]        p1_len,
   input  logic              p1_wr_n,
   input  logic [DATA_W-1:0] p1_wr_data,
   input  logic [3:0]        p1_wr_en_n,
   output logic              p1_ack,
   output logic              p1_rd_valid,
   output logic              p1_wr_next,
   output logic [DATA_W-1:0] p1_rd_data,

   output logic              sdr_req,
   output logic [ADDR_W-1:0] sdr_req_adr,
   output logic [1:0]        sdr_req_len,
   output logic              sdr_req_wr_n,
   output logic [DATA_W-1:0] sdr_wr_data,
   output logic [3:0]        sdr_wr_en_n,
   input  logic              sdr_req_ack,
   input  logic              sdr_rd_valid,
   input  logic              sdr_wr_next,
   input  logic              sdr_init_done,
   input  logic [DATA_W-1:0] sdr_rd_data,

   output logic              arb_busy,
   output logic              arb_gnt
);

   typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

   state_t            state, state_nxt;
   logic              rr, rr_nxt;
   logic              gnt, gnt_nxt;
   logic [1:0]        cnt, cnt_nxt;
   logic [ADDR_W-1:0] lat_adr, lat_adr_nxt;
   logic [1:0]        lat_len, lat_len_nxt;
   // Direction and byte enables are held active-high so that a cleared
   // register means "read, no bytes" and maps onto the idle bus levels.
   logic              lat_wr, lat_wr_nxt;
   logic [3:0]        lat_be, lat_be_nxt;

   logic any_req;
   logic winner;
   logic beat;
   logic fwd;

   assign any_req = p0_req | p1_req;
   assign winner  = (p0_req && p1_req) ? rr : p1_req;
   assign beat    = sdr_rd_valid | sdr_wr_next;
   assign fwd     = (state == XFER) || ((state == REQ) && sdr_req_ack);

   // State and latched-field registers with synchronous active-low reset
   always_ff @(posedge mclk) begin
      if (!s_resetn) begin
         state   <= IDLE;
         rr      <= 1'b0;
         gnt     <= 1'b0;
         cnt     <= 2'd0;
         lat_adr <= '0;
         lat_len <= 2'd0;
         lat_wr  <= 1'b0;
         lat_be  <= 4'h0;
      end else begin
         state   <= state_nxt;
         rr      <= rr_nxt;
         gnt     <= gnt_nxt;
         cnt     <= cnt_nxt;
         lat_adr <= lat_adr_nxt;
         lat_len <= lat_len_nxt;
         lat_wr  <= lat_wr_nxt;
         lat_be  <= lat_be_nxt;
      end
   end

   // Grant, request handshake and beat counting; a beat seen with the
   // counter at zero is the last one, including a beat in the ack cycle
   always_comb begin
      state_nxt   = state;
      rr_nxt      = rr;
      gnt_nxt     = gnt;
      cnt_nxt     = cnt;
      lat_adr_nxt = lat_adr;
      lat_len_nxt = lat_len;
      lat_wr_nxt  = lat_wr;
      lat_be_nxt  = lat_be;
      case (state)
         IDLE: begin
            if (sdr_init_done && any_req) begin
               gnt_nxt     = winner;
               lat_adr_nxt = winner ? p1_adr : p0_adr;
               lat_len_nxt = winner ? p1_len : p0_len;
               lat_wr_nxt  = ~(winner ? p1_wr_n : p0_wr_n);
               lat_be_nxt  = ~(winner ? p1_wr_en_n : p0_wr_en_n);
               state_nxt   = REQ;
            end
         end
         REQ: begin
            if (sdr_req_ack) begin
               if (beat) begin
                  if (lat_len == 2'd0) begin
                     state_nxt = IDLE;
                     rr_nxt    = ~gnt;
                  end else begin
                     cnt_nxt   = lat_len - 2'd1;
                     state_nxt = XFER;
                  end
               end else begin
                  cnt_nxt   = lat_len;
                  state_nxt = XFER;
               end
            end
         end
         XFER: begin
            if (beat) begin
               if (cnt == 2'd0) begin
                  state_nxt = IDLE;
                  rr_nxt    = ~gnt;
               end else begin
                  cnt_nxt = cnt - 2'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign sdr_req      = (state == REQ);
   assign sdr_req_adr  = lat_adr;
   assign sdr_req_len  = lat_len;
   assign sdr_req_wr_n = ~lat_wr;
   assign sdr_wr_en_n  = ~lat_be;
   assign sdr_wr_data  = gnt ? p1_wr_data : p0_wr_data;

   assign p0_ack       = (state == REQ) && sdr_req_ack && !gnt;
   assign p1_ack       = (state == REQ) && sdr_req_ack && gnt;
   assign p0_rd_valid  = fwd && !gnt && sdr_rd_valid;
   assign p1_rd_valid  = fwd && gnt && sdr_rd_valid;
   assign p0_wr_next   = fwd && !gnt && sdr_wr_next;
   assign p1_wr_next   = fwd && gnt && sdr_wr_next;
   assign p0_rd_data   = sdr_rd_data;
   assign p1_rd_data   = sdr_rd_data;

   assign arb_busy     = (state != IDLE);
   assign arb_gnt      = gnt;

endmodule

// File: tb/tb_sdc_host_arb.sv
// Self-checking bench for sdc_host_arb: expected grants are queued when
// requests are raised and popped when the arbiter drives sdr_req.
module tb_sdc_host_arb;

   typedef struct {
      bit          port;
      logic [21:0] adr;
      logic [1:0]  len;
      bit          wr_n;
      logic [3:0]  be_n;
   } exp_t;

   logic        mclk = 1'b0;
   logic        s_resetn;
   logic        p0_req, p1_req;
   logic [21:0] p0_adr, p1_adr;
   logic [1:0]  p0_len, p1_len;
   logic        p0_wr_n, p1_wr_n;
   logic [31:0] p0_wr_data, p1_wr_data;
   logic [3:0]  p0_wr_en_n, p1_wr_en_n;
   logic        p0_ack, p0_rd_valid, p0_wr_next;
   logic        p1_ack, p1_rd_valid, p1_wr_next;
   logic [31:0] p0_rd_data, p1_rd_data;
   logic        sdr_req;
   logic [21:0] sdr_req_adr;
   logic [1:0]  sdr_req_len;
   logic        sdr_req_wr_n;
   logic [31:0] sdr_wr_data;
   logic [3:0]  sdr_wr_en_n;
   logic        sdr_req_ack, sdr_rd_valid, sdr_wr_next, sdr_init_done;
   logic [31:0] sdr_rd_data;
   logic        arb_busy, arb_gnt;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   sdc_host_arb dut (
      .mclk(mclk), .s_resetn(s_resetn),
      .p0_req(p0_req), .p0_adr(p0_adr), .p0_len(p0_len), .p0_wr_n(p0_wr_n),
      .p0_wr_data(p0_wr_data), .p0_wr_en_n(p0_wr_en_n), .p0_ack(p0_ack),
      .p0_rd_valid(p0_rd_valid), .p0_wr_next(p0_wr_next), .p0_rd_data(p0_rd_data),
      .p1_req(p1_req), .p1_adr(p1_adr), .p1_len(p1_len), .p1_wr_n(p1_wr_n),
      .p1_wr_data(p1_wr_data), .p1_wr_en_n(p1_wr_en_n), .p1_ack(p1_ack),
      .p1_rd_valid(p1_rd_valid), .p1_wr_next(p1_wr_next), .p1_rd_data(p1_rd_data),
      .sdr_req(sdr_req), .sdr_req_adr(sdr_req_adr), .sdr_req_len(sdr_req_len),
      .sdr_req_wr_n(sdr_req_wr_n), .sdr_wr_data(sdr_wr_data), .sdr_wr_en_n(sdr_wr_en_n),
      .sdr_req_ack(sdr_req_ack), .sdr_rd_valid(sdr_rd_valid), .sdr_wr_next(sdr_wr_next),
      .sdr_init_done(sdr_init_done), .sdr_rd_data(sdr_rd_data),
      .arb_busy(arb_busy), .arb_gnt(arb_gnt)
   );

   // Free-running clock
   always #5 mclk = ~mclk;

   // Hard time limit so a stuck handshake can never hang the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish (actual running, required finished)");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_reset();
      checkOutput("rst_sdr_req", sdr_req, 0);
      checkOutput("rst_adr", sdr_req_adr, 0);
      checkOutput("rst_len", sdr_req_len, 0);
      checkOutput("rst_wr_n", sdr_req_wr_n, 1);
      checkOutput("rst_wr_en_n", sdr_wr_en_n, 4'hF);
      checkOutput("rst_acks", {p0_ack, p1_ack}, 0);
      checkOutput("rst_rd_valid", {p0_rd_valid, p1_rd_valid}, 0);
      checkOutput("rst_wr_next", {p0_wr_next, p1_wr_next}, 0);
      checkOutput("rst_busy", arb_busy, 0);
      checkOutput("rst_gnt", arb_gnt, 0);
   endtask

   task automatic apply_beat(input bit wr_n);
      if (wr_n) begin
         sdr_rd_data  = $urandom;
         sdr_rd_valid = 1'b1;
      end else begin
         p0_wr_data  = $urandom;
         p1_wr_data  = $urandom;
         sdr_wr_next = 1'b1;
      end
   endtask

   task automatic clear_beat();
      sdr_rd_valid = 1'b0;
      sdr_wr_next  = 1'b0;
   endtask

   task automatic check_beat(input bit g, input bit wr_n);
      if (wr_n) begin
         checkOutput("rd_valid_gnt", g ? p1_rd_valid : p0_rd_valid, 1);
         checkOutput("rd_valid_other", g ? p0_rd_valid : p1_rd_valid, 0);
         checkOutput("rd_data", g ? p1_rd_data : p0_rd_data, sdr_rd_data);
      end else begin
         checkOutput("wr_next_gnt", g ? p1_wr_next : p0_wr_next, 1);
         checkOutput("wr_next_other", g ? p0_wr_next : p1_wr_next, 0);
         checkOutput("wr_data", sdr_wr_data, g ? p1_wr_data : p0_wr_data);
      end
   endtask

   // Controller model: waits for sdr_req, compares against the scoreboard,
   // acks, then supplies up to max_beats beats. Called at negedge+1.
   task automatic serve_txn(input bit ack_beat, input int max_beats);
      exp_t e;
      int   waited;
      int   beats_left;
      bit   g;
      waited = 0;
      while (sdr_req !== 1'b1 && waited < 8) begin
         @(negedge mclk);
         #1;
         waited++;
      end
      checkOutput("req_seen", sdr_req, 1);
      if (sdr_req !== 1'b1) return;
      if (exp_q.size() == 0) begin
         checkOutput("sb_empty", 0, 1);
         return;
      end
      e = exp_q.pop_front();
      g = e.port;
      checkOutput("gnt", arb_gnt, e.port);
      checkOutput("busy_req", arb_busy, 1);
      checkOutput("req_adr", sdr_req_adr, e.adr);
      checkOutput("req_len", sdr_req_len, e.len);
      checkOutput("req_wr_n", sdr_req_wr_n, e.wr_n);
      checkOutput("req_wr_en_n", sdr_wr_en_n, e.be_n);
      checkOutput("req_wdata", sdr_wr_data, g ? p1_wr_data : p0_wr_data);
      sdr_req_ack = 1'b1;
      if (ack_beat) apply_beat(e.wr_n);
      #1;
      checkOutput("ack_gnt", g ? p1_ack : p0_ack, 1);
      checkOutput("ack_other", g ? p0_ack : p1_ack, 0);
      if (ack_beat) check_beat(g, e.wr_n);
      @(negedge mclk);
      sdr_req_ack = 1'b0;
      clear_beat();
      if (g) p1_req = 1'b0;
      else   p0_req = 1'b0;
      #1;
      checkOutput("req_drop", sdr_req, 0);
      beats_left = int'(e.len) + 1 - (ack_beat ? 1 : 0);
      for (int b = 0; b < beats_left && b < max_beats; b++) begin
         apply_beat(e.wr_n);
         #1;
         check_beat(g, e.wr_n);
         @(negedge mclk);
         clear_beat();
         #1;
      end
      if (beats_left <= max_beats) checkOutput("end_idle", arb_busy, 0);
   endtask

   task automatic applyStimulus();
      exp_t e;
      // reset state
      s_resetn = 1'b0;
      p0_req = 0; p1_req = 0;
      p0_adr = 0; p1_adr = 0; p0_len = 0; p1_len = 0;
      p0_wr_n = 1; p1_wr_n = 1; p0_wr_en_n = 4'hF; p1_wr_en_n = 4'hF;
      p0_wr_data = 0; p1_wr_data = 0;
      sdr_req_ack = 0; sdr_rd_valid = 0; sdr_wr_next = 0; sdr_init_done = 0;
      sdr_rd_data = 0;
      repeat (3) @(negedge mclk);
      #1;
      check_reset();
      s_resetn = 1'b1;

      // init gate: p0 write waits for sdr_init_done
      p0_adr = 22'h3; p0_len = 2'd0; p0_wr_n = 1'b0; p0_wr_en_n = 4'h5; p0_req = 1'b1;
      e = '{port: 1'b0, adr: 22'h3, len: 2'd0, wr_n: 1'b0, be_n: 4'h5};
      exp_q.push_back(e);
      for (int i = 0; i < 20; i++) begin
         @(negedge mclk);
         #1;
         checkOutput("gate_no_req", sdr_req, 0);
      end
      sdr_init_done = 1'b1;
      serve_txn(1'b0, 4);

      // reset in IDLE clears rr (p0 just won, so rr was 1)
      s_resetn = 1'b0;
      @(negedge mclk);
      #1;
      check_reset();
      s_resetn = 1'b1;

      // round robin: both requesting, six alternating grants from p0
      p0_adr = 22'h100; p0_len = 2'd1; p0_wr_n = 1'b1; p0_wr_en_n = 4'h0;
      p1_adr = 22'h200; p1_len = 2'd2; p1_wr_n = 1'b1; p1_wr_en_n = 4'h0;
      p0_req = 1'b1; p1_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) e = '{port: 1'b0, adr: 22'h100, len: 2'd1, wr_n: 1'b1, be_n: 4'h0};
         else            e = '{port: 1'b1, adr: 22'h200, len: 2'd2, wr_n: 1'b1, be_n: 4'h0};
         exp_q.push_back(e);
      end
      for (int i = 0; i < 6; i++) begin
         serve_txn(1'b0, 4);
         if (i < 4) begin
            if (i % 2 == 0) p0_req = 1'b1;
            else            p1_req = 1'b1;
         end
      end

      // p1 read burst of four beats
      p1_adr = 22'h1234; p1_len = 2'd3; p1_wr_n = 1'b1; p1_wr_en_n = 4'h0; p1_req = 1'b1;
      e = '{port: 1'b1, adr: 22'h1234, len: 2'd3, wr_n: 1'b1, be_n: 4'h0};
      exp_q.push_back(e);
      serve_txn(1'b0, 4);

      // p0 write burst of two beats
      p0_adr = 22'h40; p0_len = 2'd1; p0_wr_n = 1'b0; p0_wr_en_n = 4'h0; p0_req = 1'b1;
      e = '{port: 1'b0, adr: 22'h40, len: 2'd1, wr_n: 1'b0, be_n: 4'h0};
      exp_q.push_back(e);
      serve_txn(1'b0, 4);

      // single-beat read whose only beat arrives with the ack
      p0_adr = 22'h55; p0_len = 2'd0; p0_wr_n = 1'b1; p0_wr_en_n = 4'hC; p0_req = 1'b1;
      e = '{port: 1'b0, adr: 22'h55, len: 2'd0, wr_n: 1'b1, be_n: 4'hC};
      exp_q.push_back(e);
      serve_txn(1'b1, 4);

      // reset after two of four beats; an in-flight beat must be dropped
      p0_adr = 22'h2A0; p0_len = 2'd3; p0_wr_n = 1'b1; p0_wr_en_n = 4'h0; p0_req = 1'b1;
      e = '{port: 1'b0, adr: 22'h2A0, len: 2'd3, wr_n: 1'b1, be_n: 4'h0};
      exp_q.push_back(e);
      serve_txn(1'b0, 2);
      s_resetn = 1'b0;
      sdr_rd_valid = 1'b1;
      @(negedge mclk);
      #1;
      check_reset();
      s_resetn = 1'b1;
      sdr_rd_valid = 1'b0;

      // rr is back to 0, so p0 must win against p1 after the reset
      p0_adr = 22'h77; p0_len = 2'd0; p0_wr_n = 1'b1; p0_wr_en_n = 4'h0;
      p1_adr = 22'h88; p1_len = 2'd0; p1_wr_n = 1'b1; p1_wr_en_n = 4'h0;
      p0_req = 1'b1; p1_req = 1'b1;
      e = '{port: 1'b0, adr: 22'h77, len: 2'd0, wr_n: 1'b1, be_n: 4'h0};
      exp_q.push_back(e);
      e = '{port: 1'b1, adr: 22'h88, len: 2'd0, wr_n: 1'b1, be_n: 4'h0};
      exp_q.push_back(e);
      serve_txn(1'b0, 4);
      serve_txn(1'b0, 4);

      checkOutput("sb_drain", exp_q.size(), 0);
   endtask

   // Main sequence and summary
   initial begin
      applyStimulus();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
